// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute sequencer for the tau core: drives the PC load/enable controls,
// fetches instruction and operand words, resolves JMP/JC/HLT, and hands other opcodes to execute.
module fetch_sequencer #(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OPCODE_WIDTH  = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                     clock_i,
    input  logic                     reset_ni,
    input  logic                     run_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_value_i,
    input  logic                     mem_ready_i,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic                     branch_taken_i,
    input  logic                     exec_done_i,
    output logic                     pc_load_n_o,
    output logic                     pc_enable_o,
    output logic [ADDRESS_WIDTH-1:0] pc_load_address_o,
    output logic                     mem_read_o,
    output logic [ADDRESS_WIDTH-1:0] mem_address_o,
    output logic [DATA_WIDTH-1:0]    instruction_o,
    output logic                     exec_start_o,
    output logic                     halted_o,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        OPERAND = 3'd3,
        LOAD    = 3'd4,
        STEP    = 3'd5,
        EXECUTE = 3'd6,
        HALT    = 3'd7
    } state_e;

    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = '1;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OP_HLT - OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OP_HLT - OPCODE_WIDTH'(2);

    state_e                   state_q, state_d;
    logic                     pc_load_n_q, pc_load_n_d;
    logic                     pc_enable_q, pc_enable_d;
    logic [ADDRESS_WIDTH-1:0] pc_load_address_q, pc_load_address_d;
    logic                     mem_read_q, mem_read_d;
    logic [DATA_WIDTH-1:0]    instruction_q, instruction_d;
    logic                     exec_start_q, exec_start_d;
    logic                     halted_q, halted_d;
    logic                     vector_pending_q, vector_pending_d;
    logic [OPCODE_WIDTH-1:0]  opcode_c;
    state_e                   boundary_c;

    assign opcode_c = instruction_q[DATA_WIDTH-1 -: OPCODE_WIDTH];

    // Every entry to FETCH is an instruction boundary where run is honoured.
    assign boundary_c = run_i ? FETCH : IDLE;

    // Next-state logic; control outputs are derived from the next state so that
    // their registered copies line up exactly with the state they belong to.
    always_comb begin
        state_d            = state_q;
        instruction_d      = instruction_q;
        pc_load_address_d  = pc_load_address_q;
        vector_pending_d   = vector_pending_q;
        pc_load_n_d        = 1'b1;
        pc_enable_d        = 1'b0;
        mem_read_d         = 1'b0;
        exec_start_d       = 1'b0;
        halted_d           = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run_i) begin
                    if (vector_pending_q) begin
                        state_d           = LOAD;
                        pc_load_address_d = RESET_VECTOR;
                        vector_pending_d  = 1'b0;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                if (mem_ready_i) begin
                    instruction_d = mem_rdata_i;
                    state_d       = DECODE;
                end
            end
            DECODE: begin
                if (opcode_c == OP_HLT) begin
                    state_d = HALT;
                end else if ((opcode_c == OP_JMP) || (opcode_c == OP_JC)) begin
                    state_d = OPERAND;
                end else begin
                    state_d = EXECUTE;
                end
            end
            OPERAND: begin
                if (mem_ready_i) begin
                    if ((opcode_c == OP_JMP) || branch_taken_i) begin
                        pc_load_address_d = mem_rdata_i[ADDRESS_WIDTH-1:0];
                        state_d           = LOAD;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            LOAD:    state_d = boundary_c;
            STEP:    state_d = boundary_c;
            EXECUTE: begin
                if (exec_done_i) begin
                    state_d = boundary_c;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase

        pc_load_n_d  = (state_d != LOAD);
        pc_enable_d  = (state_d == DECODE) || (state_d == STEP);
        mem_read_d   = (state_d == FETCH) || (state_d == OPERAND);
        exec_start_d = (state_q == DECODE) && (state_d == EXECUTE);
        halted_d     = (state_d == HALT);
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= IDLE;
            pc_load_n_q       <= 1'b1;
            pc_enable_q       <= 1'b0;
            pc_load_address_q <= '0;
            mem_read_q        <= 1'b0;
            instruction_q     <= '0;
            exec_start_q      <= 1'b0;
            halted_q          <= 1'b0;
            vector_pending_q  <= 1'b1;
        end else begin
            state_q           <= state_d;
            pc_load_n_q       <= pc_load_n_d;
            pc_enable_q       <= pc_enable_d;
            pc_load_address_q <= pc_load_address_d;
            mem_read_q        <= mem_read_d;
            instruction_q     <= instruction_d;
            exec_start_q      <= exec_start_d;
            halted_q          <= halted_d;
            vector_pending_q  <= vector_pending_d;
        end
    end

    assign pc_load_n_o       = pc_load_n_q;
    assign pc_enable_o       = pc_enable_q;
    assign pc_load_address_o = pc_load_address_q;
    assign mem_read_o        = mem_read_q;
    assign mem_address_o     = pc_value_i;
    assign instruction_o     = instruction_q;
    assign exec_start_o      = exec_start_q;
    assign halted_o          = halted_q;
    assign state_o           = state_q;

endmodule
